// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and helpers for the port-A RAM arbiter.
//   state_t   : arbiter FSM states
//   LEGAL_WE  : byte-enable patterns the byte-lane RAM accepts
//   we_legal(): 1 when a byte-enable pattern may reach the RAM
package ram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam int WE_BITS = 4;
  localparam int N_LEGAL = 8;

  // Single bytes, aligned halfwords, full word, and 0000 (read).
  localparam logic [N_LEGAL*WE_BITS-1:0] LEGAL_WE = {
    4'b0000, 4'b0001, 4'b0010, 4'b0100,
    4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic we_legal(input logic [WE_BITS-1:0] we);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL; i++)
      if (LEGAL_WE[i*WE_BITS +: WE_BITS] == we) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: one requester's req/ack channel into the arbiter.
//   req/addr/we/din : requester -> arbiter, held stable until ack
//   ack             : one-cycle completion pulse
//   dout/err        : read data and illegal-byte-enable flag, qualified by ack
// master = requester side, slave = arbiter side.
interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL*COL_WIDTH
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [NUM_COL-1:0]    we;
  logic [DATA_WIDTH-1:0] din;
  logic                  ack;
  logic [DATA_WIDTH-1:0] dout;
  logic                  err;

  modport master (output req, addr, we, din, input  ack, dout, err);
  modport slave  (input  req, addr, we, din, output ack, dout, err);
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   en       : grants are only produced while en=1 (arbiter FSM in IDLE)
//   req[1:0] : request vector
//   gnt_vld  : a grant is issued this cycle
//   gnt_id   : granted requester index
// last_grant resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt_vld,
  output logic       gnt_id
);
  logic last_grant;

  always_comb begin
    gnt_vld = en & (|req);
    // On a tie the requester that did not win last time goes first.
    gnt_id  = (req == 2'b11) ? ~last_grant : req[1];
  end

  always_ff @(posedge clk) begin
    if (rst)          last_grant <= 1'b1;
    else if (gnt_vld) last_grant <= gnt_id;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RAM write port A between m0 (CPU LSU) and m1
// (boot loader / DMA). One transaction every 3 cycles: IDLE grants,
// ISSUE drives the RAM for one cycle, RESP pulses ack with read data.
//   clk, rst      : clock, synchronous active-high reset
//   m0, m1        : requester channels (slave modport)
//   ram_ena/we/addr/din : RAM port A command, registered
//   ram_dout      : RAM port A read data, one cycle after ram_ena
// Illegal byte-enable patterns are dropped to 0000 and reported via err.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL*COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_port_arbiter_if.slave     m0,
  ram_port_arbiter_if.slave     m1,
  output logic                  ram_ena,
  output logic [NUM_COL-1:0]    ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  state_t state, state_nxt;

  logic                  gnt_vld, gnt_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [NUM_COL-1:0]    sel_we;
  logic [DATA_WIDTH-1:0] sel_din;
  logic                  sel_legal;

  logic                  gid;      // requester owning the current transaction
  logic                  rd;       // current transaction is a read
  logic                  err_f;    // current transaction had illegal we
  logic [1:0]            ack_q;
  logic [1:0]            err_q;
  logic [1:0][DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] resp_data;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (state == IDLE),
    .req     ({m1.req, m0.req}),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign sel_addr  = gnt_id ? m1.addr : m0.addr;
  assign sel_we    = gnt_id ? m1.we   : m0.we;
  assign sel_din   = gnt_id ? m1.din  : m0.din;
  assign sel_legal = we_legal(sel_we);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The RAM command registers double as the latched request: they are
  // loaded on the grant and so present exactly during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ram_ena  <= 1'b0;
      ram_we   <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      gid      <= 1'b0;
      rd       <= 1'b0;
      err_f    <= 1'b0;
      ack_q    <= '0;
      err_q    <= '0;
      dout_q   <= '0;
    end else begin
      state   <= state_nxt;
      ram_ena <= 1'b0;
      ram_we  <= '0;
      ack_q   <= '0;
      if (state == IDLE && gnt_vld) begin
        ram_ena  <= 1'b1;
        ram_addr <= sel_addr;
        ram_we   <= sel_legal ? sel_we : '0;
        ram_din  <= sel_din;
        gid      <= gnt_id;
        rd       <= (sel_we == '0);
        err_f    <= ~sel_legal;
      end
      if (state == ISSUE) begin
        ack_q[gid] <= 1'b1;
        err_q[gid] <= err_f;
      end
      // Capture the response so dout holds until the next ack.
      if (state == RESP) dout_q[gid] <= resp_data;
    end
  end

  // RAM read data arrives during RESP; pass it straight through then.
  assign resp_data = rd ? ram_dout : '0;

  assign m0.ack  = ack_q[0];
  assign m1.ack  = ack_q[1];
  assign m0.err  = err_q[0];
  assign m1.err  = err_q[1];
  assign m0.dout = (state == RESP && !gid) ? resp_data : dout_q[0];
  assign m1.dout = (state == RESP &&  gid) ? resp_data : dout_q[1];
endmodule
